// File: rtl/cal_seq.sv
// cal_seq: bit-serial ALU sequencer.
// One 1-bit ALU cell (logic cell + full adder, muxed by arit) is reused
// LSB-first over N clock edges. The FSM runs IDLE -> RUN (N edges) -> DONE (1 cycle).
// Optional feature macro: CAL_SEQ_FLAGS_EN adds the zero/ovf status outputs.
//
// Handshake: start is sampled only in IDLE; the accepting edge also captures
// a/b/s/arit/c_in. busy is high exactly while bits are being processed. done is
// a one-cycle pulse during which result/c_out are valid. Both stay held until
// the next accepted start.
module cal_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   s,
  input  logic         arit,
  input  logic         c_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         c_out,
`ifdef CAL_SEQ_FLAGS_EN
  output logic         zero,
  output logic         ovf,
`endif
  output logic [1:0]   dbg_state
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_sh_q, a_sh_d;
  logic [N-1:0]   b_sh_q, b_sh_d;
  logic [N-1:0]   res_sh_q, res_sh_d;
  logic [N-1:0]   result_q, result_d;
  logic [1:0]     s_q, s_d;
  logic           arit_q, arit_d;
  logic           carry_q, carry_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           c_out_q, c_out_d;
`ifdef CAL_SEQ_FLAGS_EN
  logic           zero_q, zero_d;
  logic           ovf_q, ovf_d;
`endif

  logic           cell_a, cell_b;
  logic           cell_logic, cell_sum, cell_co, cell_out;
  logic           last_bit;

  // The single 1-bit ALU cell: logic function, full adder and output mux.
  always_comb begin
    cell_a = a_sh_q[0];
    cell_b = b_sh_q[0];
    unique case (s_q)
      2'b00:   cell_logic = cell_a & cell_b;
      2'b01:   cell_logic = cell_a | cell_b;
      2'b10:   cell_logic = cell_a ^ cell_b;
      default: cell_logic = ~cell_a;
    endcase
    cell_sum = cell_a ^ cell_b ^ carry_q;
    cell_co  = (cell_a & cell_b) | (carry_q & (cell_a ^ cell_b));
    cell_out = arit_q ? cell_sum : cell_logic;
  end

  assign last_bit = (cnt_q == CW'(N - 1));

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    result_d = result_q;
    s_d      = s_q;
    arit_d   = arit_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    c_out_d  = c_out_q;
`ifdef CAL_SEQ_FLAGS_EN
    zero_d   = zero_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          s_d     = s;
          arit_d  = arit;
          carry_d = arit & c_in;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = {cell_out, res_sh_q[N-1:1]};
        carry_d  = cell_co;
        if (last_bit) begin
          // Publish the completed word only now so result never shows a
          // partial value.
          cnt_d    = '0;
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = res_sh_d;
          c_out_d  = arit_q & cell_co;
`ifdef CAL_SEQ_FLAGS_EN
          zero_d   = (res_sh_d == '0);
          // carry_q is the carry into the MSB during the final bit.
          ovf_d    = arit_q & (carry_q ^ cell_co);
`endif
        end else begin
          cnt_d  = cnt_q + 1'b1;
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state registers; synchronous reset overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      s_q      <= '0;
      arit_q   <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      c_out_q  <= 1'b0;
`ifdef CAL_SEQ_FLAGS_EN
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      result_q <= result_d;
      s_q      <= s_d;
      arit_q   <= arit_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      c_out_q  <= c_out_d;
`ifdef CAL_SEQ_FLAGS_EN
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign c_out     = c_out_q;
  assign dbg_state = state_q;
`ifdef CAL_SEQ_FLAGS_EN
  assign zero      = zero_q;
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cal_seq.sv
// tb_cal_seq: directed bench for cal_seq (N=8) with an expected-result queue.
module tb_cal_seq;

  localparam int N = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] a, b;
  logic [1:0]   s;
  logic         arit, c_in;
  logic         busy, done, c_out;
  logic [N-1:0] result;
  logic [1:0]   dbg_state;
  logic         zero_o, ovf_o;

  int n_checks = 0;
  int n_errors = 0;

  // Packed expectation: {ovf, c_out, result}
  logic [N+1:0] exp_q[$];
  logic [N+1:0] last_exp;

  cal_seq #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .s         (s),
    .arit      (arit),
    .c_in      (c_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .c_out     (c_out),
`ifdef CAL_SEQ_FLAGS_EN
    .zero      (zero_o),
    .ovf       (ovf_o),
`endif
    .dbg_state (dbg_state)
  );

`ifndef CAL_SEQ_FLAGS_EN
  assign zero_o = 1'b0;
  assign ovf_o  = 1'b0;
`endif

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: whole-word arithmetic, no bit-serial modelling.
  function automatic logic [N+1:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                         input logic [1:0] ms, input logic mar, input logic mci);
    logic [N:0]   sum;
    logic [N-1:0] res;
    logic         co, ov;
    co = 1'b0;
    ov = 1'b0;
    if (mar) begin
      sum = {1'b0, ma} + {1'b0, mb} + {{N{1'b0}}, mci};
      res = sum[N-1:0];
      co  = sum[N];
      ov  = (ma[N-1] == mb[N-1]) && (res[N-1] != ma[N-1]);
    end else begin
      case (ms)
        2'b00:   res = ma & mb;
        2'b01:   res = ma | mb;
        2'b10:   res = ma ^ mb;
        default: res = ~ma;
      endcase
    end
    return {ov, co, res};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: present operands with start at a negedge; they are captured at the next posedge.
  task automatic drive_start(input logic [N-1:0] da, input logic [N-1:0] db,
                             input logic [1:0] ds, input logic dar, input logic dci);
    @(negedge clk);
    start = 1'b1;
    a = da; b = db; s = ds; arit = dar; c_in = dci;
  endtask

  task automatic scramble_inputs();
    a    = N'($urandom_range(0, 255));
    b    = N'($urandom_range(0, 255));
    s    = 2'($urandom_range(0, 3));
    arit = 1'($urandom_range(0, 1));
    c_in = 1'($urandom_range(0, 1));
  endtask

  // Called at the negedge right after the accepting edge. Counts busy cycles,
  // then checks the done cycle against the head of the expected queue.
  task automatic wait_done(input string tag);
    int cyc;
    logic [N+1:0] e;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_busy_len"}, 32'(cyc), 32'(N));
    check({tag, "_done"}, 32'(done), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    last_exp = e;
    check({tag, "_result"}, 32'(result), 32'(e[N-1:0]));
    check({tag, "_c_out"},  32'(c_out),  32'(e[N]));
`ifdef CAL_SEQ_FLAGS_EN
    check({tag, "_zero"}, 32'(zero_o), 32'(e[N-1:0] == '0));
    check({tag, "_ovf"},  32'(ovf_o),  32'(e[N+1]));
`endif
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] da, input logic [N-1:0] db,
                        input logic [1:0] ds, input logic dar, input logic dci);
    drive_start(da, db, ds, dar, dci);
    exp_q.push_back(model(da, db, ds, dar, dci));
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();
    wait_done(tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"},  32'(busy), 32'd0);
  endtask

  initial begin
    int dones;
    logic [N-1:0] ra, rb;
    logic [1:0]   rs;
    logic         rar, rci;

    start = 1'b0; a = '0; b = '0; s = '0; arit = 1'b0; c_in = 1'b0;
    reset = 1'b1;
    last_exp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_c_out",  32'(c_out),  32'd0);
    check("rst_state",  32'(dbg_state), 32'd0);

    // Directed arithmetic and logic cases
    run_op("add_35_4a", 8'h35, 8'h4A, 2'b00, 1'b1, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 2'b00, 1'b1, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 2'b00, 1'b1, 1'b0);
    run_op("xor_c3_a5", 8'hC3, 8'hA5, 2'b10, 1'b0, 1'b0);
    run_op("and_c3_a5", 8'hC3, 8'hA5, 2'b00, 1'b0, 1'b1);
    run_op("or_c3_a5",  8'hC3, 8'hA5, 2'b01, 1'b0, 1'b0);
    run_op("not_c3",    8'hC3, 8'hA5, 2'b11, 1'b0, 1'b1);
    run_op("add_cin",   8'h80, 8'h7F, 2'b00, 1'b1, 1'b1);
    run_op("add_neg",   8'h80, 8'h80, 2'b00, 1'b1, 1'b0);

    // Result is held through idle cycles
    repeat (4) @(negedge clk);
    check("hold_result", 32'(result), 32'(last_exp[N-1:0]));
    check("hold_c_out",  32'(c_out),  32'(last_exp[N]));

    // Random operations
    for (int i = 0; i < 6; i++) begin
      ra  = N'($urandom_range(0, 255));
      rb  = N'($urandom_range(0, 255));
      rs  = 2'($urandom_range(0, 3));
      rar = 1'($urandom_range(0, 1));
      rci = 1'($urandom_range(0, 1));
      run_op("rand", ra, rb, rs, rar, rci);
    end

    // start held high through RUN and DONE with new operands
    drive_start(8'h35, 8'h4A, 2'b00, 1'b1, 1'b0);
    exp_q.push_back(model(8'h35, 8'h4A, 2'b00, 1'b1, 1'b0));
    @(negedge clk);
    a = 8'h11; b = 8'h22; s = 2'b01; arit = 1'b0; c_in = 1'b1;
    wait_done("held1");
    @(negedge clk);
    check("held_gap_busy", 32'(busy), 32'd0);
    check("held_gap_done", 32'(done), 32'd0);
    check("held_gap_result", 32'(result), 32'h7F);
    exp_q.push_back(model(8'h11, 8'h22, 2'b01, 1'b0, 1'b1));
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();
    wait_done("held2");
    @(negedge clk);

    // Reset at the 4th RUN edge abandons the operation
    drive_start(8'hAA, 8'h55, 2'b00, 1'b1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy",   32'(busy),   32'd0);
    check("abort_done",   32'(done),   32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_c_out",  32'(c_out),  32'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    run_op("after_abort", 8'hFF, 8'h01, 2'b00, 1'b1, 1'b0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cal_seq.md
CAL_SEQ -- requirements
Module: cal_seq

Interface
REQ-001 Parameter: N, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 a  input  N  operand A; captured on accepted start.
REQ-006 b  input  N  operand B; captured on accepted start.
REQ-007 s  input  2  logic-cell select; captured on accepted start.
REQ-008 arit  input  1  1 = arithmetic (full adder), 0 = logic cell; captured on accepted start.
REQ-009 c_in  input  1  initial carry for arithmetic; captured on accepted start.
REQ-010 busy  output  1  high while bits are being processed.
REQ-011 done  output  1  one-cycle pulse; result valid.
REQ-012 result  output  N  operation result, held until next accepted start.
REQ-013 c_out  output  1  final carry out (arithmetic only).

Function
REQ-014 Block SHALL contain exactly one 1-bit ALU cell (logic cell, full adder, output mux on arit) and reuse it bit-serially, LSB first.
REQ-015 Logic encoding SHALL be s=00 AND, 01 OR, 10 XOR, 11 NOT a.
REQ-016 FSM states SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-017 IDLE: on start=1 at an edge, SHALL latch a, b, s, arit into shift/config registers, load carry register with c_in when arit=1 (else 0), clear bit counter, go to RUN.
REQ-018 RUN: each edge SHALL feed operand LSBs to the cell, shift both operand registers right, shift cell output into result MSB, load carry register from cell carry, increment counter.
REQ-019 RUN SHALL last exactly N edges; edge N moves to DONE with result complete (bit 0 in result[0]).
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-021 Latency: start sampled at edge k -> done high during cycle after edge k+N; next start accepted no earlier than edge k+N+1.
REQ-022 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-023 start SHALL be ignored in RUN and DONE; operand/config inputs SHALL be ignored outside the accepting edge.
REQ-024 c_out SHALL equal final carry register when latched arit=1, and 0 when arit=0; updated at RUN->DONE, held thereafter.
REQ-025 result SHALL hold its last value in IDLE and SHALL not be externally visible as valid while busy=1.

Reset
REQ-026 reset=1 at an edge SHALL force IDLE, busy=0, done=0, result=0, c_out=0, counter=0, carry register=0, overriding all other inputs including start.
REQ-027 Reset during RUN or DONE SHALL abandon the operation with no done pulse.

Configuration
REQ-028 Macro CAL_SEQ_FLAGS_EN, when defined, SHALL add outputs zero (1 bit, result==0) and ovf (1 bit, carry into MSB XOR carry out, arit=1 only, else 0), both updated at RUN->DONE, held, reset to 0.
REQ-029 Without CAL_SEQ_FLAGS_EN the zero/ovf ports and their logic SHALL be absent; all other behaviour identical.

Verification (N=8)
REQ-030 a=0x35, b=0x4A, arit=1, c_in=0, start at edge k -> busy edges k..k+7, done after edge k+8, result=0x7F, c_out=0.
REQ-031 a=0xFF, b=0x01, arit=1, c_in=0 -> result=0x00, c_out=1; with flags: zero=1, ovf=0.
REQ-032 a=0x7F, b=0x01, arit=1, c_in=0 -> result=0x80, c_out=0; with flags: ovf=1, zero=0.
REQ-033 a=0xC3, b=0xA5, arit=0, s=10 -> result=0x66, c_out=0; s=00 -> 0x81; s=11 -> 0x3C.
REQ-034 start held high during RUN with new operands -> ignored; first result unchanged; second operation starts only after return to IDLE.
REQ-035 reset asserted at 4th RUN edge -> next cycle busy=0, done=0, result=0, c_out=0; no done pulse; fresh start then completes normally.
